// File: rtl/mem_copy_engine_if.sv
// Bundles the request/status handshake and the single-port memory bus of the copy engine.
// The slave modport is the engine; the master modport is whoever issues requests and owns the memory.
interface mem_copy_engine_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [15:0]           len_words;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [15:0]           words_done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_rdata;
    logic                  mem_enable;
    logic                  mem_wr;

    modport slave (
        input  start, src_addr, dst_addr, len_words, mem_rdata,
        output busy, done, err, words_done, mem_addr, mem_wdata, mem_enable, mem_wr
    );

    modport master (
        output start, src_addr, dst_addr, len_words, mem_rdata,
        input  busy, done, err, words_done, mem_addr, mem_wdata, mem_enable, mem_wr
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: each 16-bit word is one READ cycle then one WRITE cycle
// on a shared single-port memory, walking both addresses upward with modular wrap.
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_copy_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(2);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [15:0]           data_q, data_d;
    logic [15:0]           words_done_q, words_done_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            data_q       <= '0;
            words_done_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            remaining_q  <= remaining_d;
            data_q       <= data_d;
            words_done_q <= words_done_d;
            err_q        <= err_d;
        end
    end

    // Requests are only looked at in IDLE, so a start while busy cannot disturb a transfer.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        remaining_d  = remaining_q;
        data_d       = data_q;
        words_done_d = words_done_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.src_addr[0] || bus.dst_addr[0]) begin
                        err_d = 1'b1;
                    end else begin
                        err_d        = 1'b0;
                        words_done_d = '0;
                        if (bus.len_words == 16'd0) begin
                            state_d = DONE;
                        end else begin
                            src_d       = bus.src_addr;
                            dst_d       = bus.dst_addr;
                            remaining_d = bus.len_words;
                            state_d     = READ;
                        end
                    end
                end
            end
            READ: begin
                data_d  = bus.mem_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                src_d        = src_q + ADDR_STEP;
                dst_d        = dst_q + ADDR_STEP;
                remaining_d  = remaining_q - 16'd1;
                words_done_d = words_done_q + 16'd1;
                state_d      = (remaining_q == 16'd1) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs decode purely from the state register, so reset silences them at once.
    always_comb begin
        bus.mem_enable = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.done       = 1'b0;
        bus.busy       = (state_q != IDLE);

        unique case (state_q)
            READ: begin
                bus.mem_enable = 1'b1;
                bus.mem_addr   = src_q;
            end
            WRITE: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_addr   = dst_q;
                bus.mem_wdata  = data_q;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.err        = err_q;
    assign bus.words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural memory plus a reference copy model
// that replays each accepted transfer word by word on a shadow array.
module tb_mem_copy_engine;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n;

    mem_copy_engine_if #(.ADDR_WIDTH(AW)) bus ();

    mem_copy_engine #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem    [0:32767];
    logic [15:0] refMem [0:32767];

    int totalChecks = 0;
    int badChecks   = 0;

    int busyCount   = 0;
    int doneCount   = 0;
    int enableCount = 0;
    int protoErr    = 0;
    logic [AW-1:0] readAddrs [$];

    assign bus.mem_rdata = mem[bus.mem_addr[AW-1:1]];

    // The memory commits a write on the rising edge, seeing the pre-edge bus values.
    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr[AW-1:1]] = bus.mem_wdata;
    end

    // Sampled on the falling edge: activity counters and bus rules that must hold every cycle.
    always @(negedge clk) begin
        if (bus.busy) busyCount++;
        if (bus.done) doneCount++;
        if (bus.mem_enable) enableCount++;
        if (bus.mem_enable && !bus.mem_wr) readAddrs.push_back(bus.mem_addr);
        if (!bus.busy && (bus.mem_enable || bus.mem_wr || bus.mem_addr != '0 || bus.mem_wdata != 16'd0 || bus.done))
            protoErr++;
        if (!(bus.mem_enable && bus.mem_wr) && bus.mem_wdata != 16'd0) protoErr++;
        if (bus.mem_wr && !bus.mem_enable) protoErr++;
        if (bus.done && bus.mem_enable) protoErr++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: a copy is len ascending word moves, each address wrapping at 64 KiB.
    function automatic void refCopy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            int s = (int'(src) + 2 * i) % 65536;
            int d = (int'(dst) + 2 * i) % 65536;
            refMem[d / 2] = refMem[s / 2];
        end
    endfunction

    function automatic int memDiff();
        int n = 0;
        for (int i = 0; i < 32768; i++) if (mem[i] !== refMem[i]) n++;
        return n;
    endfunction

    task automatic pokeWord(input int byteAddr, input logic [15:0] value);
        mem[byteAddr / 2]    = value;
        refMem[byteAddr / 2] = value;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [15:0] len);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.src_addr  = src;
        bus.dst_addr  = dst;
        bus.len_words = len;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int cycles = 0;
        while (bus.busy && cycles < 2000) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (bus.busy) checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    // Runs one accepted transfer and checks count, done pulse, busy length and memory image.
    task automatic runCopy(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len);
        int b0 = busyCount;
        int d0 = doneCount;
        applyStimulus(src, dst, 16'(len));
        waitIdle(tag);
        refCopy(src, dst, len);
        checkOutput({tag, "_words"}, 64'(bus.words_done), 64'(len));
        checkOutput({tag, "_busy"}, 64'(busyCount - b0), 64'(2 * len + 1));
        checkOutput({tag, "_doneCnt"}, 64'(doneCount - d0), 64'd1);
        checkOutput({tag, "_err"}, 64'(bus.err), 64'd0);
        checkOutput({tag, "_memDiff"}, 64'(memDiff()), 64'd0);
    endtask

    initial begin
        int b0, d0, e0, r0, w;
        logic [AW-1:0] src, dst;
        int len;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.len_words = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]    = 16'($urandom);
            refMem[i] = mem[i];
        end
        pokeWord(16'h0100, 16'h1111);
        pokeWord(16'h0102, 16'h2222);
        pokeWord(16'h0104, 16'h3333);
        pokeWord(16'h0106, 16'h4444);

        repeat (3) @(negedge clk);
        checkOutput("resetOutputs",
                    {11'd0, bus.busy, bus.done, bus.err, bus.words_done, bus.mem_addr,
                     bus.mem_wdata, bus.mem_enable, bus.mem_wr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic four-word copy");
        runCopy("basic", 16'h0100, 16'h0200, 4);
        checkOutput("basicWord3", 64'(mem[16'h0206 / 2]), 64'h4444);

        $display("[TB] odd address rejection");
        b0 = busyCount;
        e0 = enableCount;
        applyStimulus(16'h0101, 16'h0200, 16'd2);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("oddErr", 64'(bus.err), 64'd1);
        checkOutput("oddBusy", 64'(busyCount - b0), 64'd0);
        checkOutput("oddEnable", 64'(enableCount - e0), 64'd0);
        runCopy("errClear", 16'h0100, 16'h0800, 1);

        $display("[TB] zero-length request");
        e0 = enableCount;
        runCopy("zeroLen", 16'h0300, 16'h0400, 0);
        checkOutput("zeroLenEnable", 64'(enableCount - e0), 64'd0);

        $display("[TB] address wrap");
        r0 = readAddrs.size();
        runCopy("wrap", 16'hFFFE, 16'h1000, 2);
        checkOutput("wrapReadCnt", 64'(readAddrs.size() - r0), 64'd2);
        if (readAddrs.size() - r0 == 2) checkOutput("wrapRead2", 64'(readAddrs[r0 + 1]), 64'h0000);

        $display("[TB] start ignored while busy");
        b0 = busyCount;
        d0 = doneCount;
        applyStimulus(16'h0100, 16'h0A00, 16'd3);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.src_addr  = 16'h0501;
        bus.dst_addr  = 16'h0600;
        bus.len_words = 16'd6;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        waitIdle("ignore");
        refCopy(16'h0100, 16'h0A00, 3);
        checkOutput("ignoreWords", 64'(bus.words_done), 64'd3);
        checkOutput("ignoreBusy", 64'(busyCount - b0), 64'd7);
        checkOutput("ignoreDone", 64'(doneCount - d0), 64'd1);
        checkOutput("ignoreErr", 64'(bus.err), 64'd0);
        checkOutput("ignoreMem", 64'(memDiff()), 64'd0);

        $display("[TB] reset during third write");
        for (int i = 0; i < 8; i++) pokeWord(16'h4000 + 2 * i, ~refMem[(16'h3000 + 2 * i) / 2]);
        d0 = doneCount;
        applyStimulus(16'h3000, 16'h4000, 16'd8);
        w = 0;
        for (int c = 0; c < 100 && w < 3; c++) begin
            if (bus.mem_enable && bus.mem_wr) w++;
            if (w < 3) begin
                @(negedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midResetOutputs",
                    {11'd0, bus.busy, bus.done, bus.err, bus.words_done, bus.mem_addr,
                     bus.mem_wdata, bus.mem_enable, bus.mem_wr}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        refCopy(16'h3000, 16'h4000, 2);
        checkOutput("midResetDone", 64'(doneCount - d0), 64'd0);
        checkOutput("midResetMem", 64'(memDiff()), 64'd0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 8; n++) begin
            src = AW'($urandom) & 16'hFFFE;
            len = int'($urandom_range(1, 12));
            if (n % 3 == 0) dst = src + AW'(2 * $urandom_range(1, 3));
            else dst = AW'($urandom) & 16'hFFFE;
            runCopy($sformatf("rand%0d", n), src, dst, len);
        end

        checkOutput("protocol", 64'(protoErr), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the byte-address width of all address ports and counters.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a copy; sampled only in IDLE.
REQ-005 src_addr  input  ADDR_WIDTH  SHALL be the source byte address, sampled with start.
REQ-006 dst_addr  input  ADDR_WIDTH  SHALL be the destination byte address, sampled with start.
REQ-007 len_words  input  16  SHALL be the number of 16-bit words to copy, sampled with start.
REQ-008 busy  output  1  SHALL be high in every state except IDLE.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 err  output  1  SHALL flag a rejected request; held until the next accepted start.
REQ-011 words_done  output  16  SHALL count words written in the current or last transfer.
REQ-012 mem_addr  output  ADDR_WIDTH  SHALL drive the memory byte address.
REQ-013 mem_wdata  output  16  SHALL drive the memory write-data input.
REQ-014 mem_rdata  input  16  SHALL be the combinational memory read data.
REQ-015 mem_enable  output  1  SHALL drive the memory enable.
REQ-016 mem_wr  output  1  SHALL drive the memory write strobe (1 = write, 0 = read).

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-018 IDLE: mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0, done=0.
REQ-019 IDLE + start with src_addr[0] or dst_addr[0] = 1 -> err=1, stay IDLE, no memory access.
REQ-020 IDLE + start, both addresses even, len_words=0 -> err=0, words_done=0, go DONE, no memory access.
REQ-021 IDLE + start, both addresses even, len_words>0 -> latch cur_src, cur_dst, remaining=len_words; err=0, words_done=0; go READ.
REQ-022 READ: mem_enable=1, mem_wr=0, mem_addr=cur_src; on the clock edge latch mem_rdata into a data buffer, go WRITE.
REQ-023 WRITE: mem_enable=1, mem_wr=1, mem_addr=cur_dst, mem_wdata=buffer; on the clock edge cur_src+=2, cur_dst+=2, remaining-=1, words_done+=1.
REQ-024 WRITE exit: remaining=1 -> DONE; otherwise -> READ.
REQ-025 DONE: done=1 for exactly one cycle, memory outputs as in IDLE, then IDLE.
REQ-026 Read and write SHALL never be requested in the same cycle; each word takes exactly 2 cycles; busy lasts 2*len_words+1 cycles.
REQ-027 Address increment SHALL wrap modulo 2^ADDR_WIDTH (0xFFFE + 2 = 0x0000 at default width).
REQ-028 Copy order SHALL be ascending. Overlap with dst > src is not protected; later source words may already be overwritten.
REQ-029 start asserted while busy SHALL be ignored, with no effect on the transfer, err, or latched operands.
REQ-030 mem_wdata SHALL be 0 in every state except WRITE.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, independent of clk.
REQ-032 Reset values: busy=0, done=0, err=0, words_done=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0; internal buffer and counters cleared.
REQ-033 Reset mid-transfer SHALL abort with no further memory writes and no done pulse; words already written remain in memory.

Verification
REQ-034 mem[0x0100..0x0106] = 0x1111,0x2222,0x3333,0x4444; start with src=0x0100, dst=0x0200, len=4 -> mem[0x0200..0x0206] match; busy high for 9 cycles; done pulses once; words_done=4.
REQ-035 Start with src=0x0101, dst=0x0200, len=2 -> err=1, busy stays 0, mem_enable never 1; a following valid start clears err.
REQ-036 Start with len=0 -> busy high for 1 cycle, done pulse, words_done=0, no mem_enable.
REQ-037 Start with src=0xFFFE, dst=0x1000, len=2 -> second read at address 0x0000; mem[0x1000]=mem[0xFFFE], mem[0x1002]=mem[0x0000].
REQ-038 Start with len=8; pull rst low during the 3rd WRITE -> outputs zero at once; exactly 2 destination words changed; no done pulse.
REQ-039 Pulse start with new operands mid-transfer (src=0x0100, len=3) -> ignored; the original transfer completes unchanged with words_done=3.
